// File: rtl/conv_core_seq_if.sv
// conv_core_seq_if: request/response bundle between the window buffer, the
// sequential convolution core and the output feature-map writer.
interface conv_core_seq_if #(
   parameter int KSIZE  = 7,
   parameter int IMG_W  = 8,
   parameter int WEI_W  = 16,
   parameter int BIAS_W = 32,
   parameter int OUT_W  = 32
) ();
   localparam int TAPS = KSIZE * KSIZE;

   logic                     enable;
   logic                     ready;
   logic [TAPS*IMG_W-1:0]    ima;
   logic [TAPS*WEI_W-1:0]    wei;
   logic signed [BIAS_W-1:0] bias;
   logic                     relu_en;
   logic signed [OUT_W-1:0]  out_reg;
   logic                     valid;
   logic                     out_ready;

   // Requester/consumer side.
   modport master (
      output enable, ima, wei, bias, relu_en, out_ready,
      input  ready, out_reg, valid
   );

   // Core side.
   modport slave (
      input  enable, ima, wei, bias, relu_en, out_ready,
      output ready, out_reg, valid
   );
endinterface

// File: rtl/conv_core_seq.sv
// conv_core_seq: multi-beat KSIZE x KSIZE signed convolution. One window is
// latched on acceptance, reduced LANES taps per beat, then bias-added,
// shifted, optionally rectified and saturated into a registered result.
module conv_core_seq #(
   parameter int KSIZE  = 7,
   parameter int IMG_W  = 8,
   parameter int WEI_W  = 16,
   parameter int BIAS_W = 32,
   parameter int OUT_W  = 32,
   parameter int LANES  = 7,
   parameter int SHIFT  = 0
) (
   input logic             clk,
   input logic             rst,
   conv_core_seq_if.slave  bus
);
   localparam int TAPS     = KSIZE * KSIZE;
   localparam int BEATS    = (TAPS + LANES - 1) / LANES;
   localparam int PAD_TAPS = BEATS * LANES;
   localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PROD_W   = IMG_W + WEI_W;
   localparam int ACC_W    = PROD_W + $clog2(TAPS) + 1;
   localparam int SUM_W    = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;
   localparam int SAT_W    = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

   localparam logic signed [SAT_W-1:0] OUT_MAX = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] OUT_MIN = {{(SAT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, POST, OUT} state_t;

   state_t                   state, state_nx;
   logic                     accept;
   logic                     last_beat;
   logic [BEAT_W-1:0]        beat;

   // Operands are kept as shift registers: lanes always read entries
   // 0..LANES-1 and each beat moves the next group of taps down.
   logic signed [IMG_W-1:0]  ima_q [PAD_TAPS];
   logic signed [WEI_W-1:0]  wei_q [PAD_TAPS];
   logic signed [BIAS_W-1:0] bias_q;
   logic                     relu_q;

   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  beat_sum;
   logic signed [PROD_W-1:0] prod;
   logic signed [SAT_W-1:0]  sum;
   logic signed [SAT_W-1:0]  shifted;
   logic signed [OUT_W-1:0]  result;
   logic signed [OUT_W-1:0]  out_q;

   assign accept    = bus.enable && bus.ready;
   assign last_beat = (beat == BEAT_W'(BEATS - 1));
   assign bus.out_reg = out_q;

   // State register.
   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode.
   // NOTE: every combinational output gets a default first; a path that
   // leaves a variable unassigned would infer a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept)        state_nx = MAC;
         MAC:     if (last_beat)     state_nx = POST;
         POST:                       state_nx = OUT;
         OUT:     if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // Handshake outputs; ready is forced low while reset is asserted.
   always_comb begin
      bus.ready = (state == IDLE) && !rst;
      bus.valid = (state == OUT);
   end

   // Operand capture on acceptance, then shift one lane group per MAC beat.
   // NOTE: the operand array is deliberately not reset; it is fully reloaded
   // (padding included) on every acceptance, so an aborted packet cannot leak.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < PAD_TAPS; i++) begin
            if (i < TAPS) begin
               ima_q[i] <= bus.ima[i*IMG_W +: IMG_W];
               wei_q[i] <= bus.wei[i*WEI_W +: WEI_W];
            end else begin
               ima_q[i] <= '0;
               wei_q[i] <= '0;
            end
         end
         bias_q <= bus.bias;
         relu_q <= bus.relu_en;
      end else if (state == MAC) begin
         for (int i = 0; i < PAD_TAPS; i++) begin
            if (i + LANES < PAD_TAPS) begin
               ima_q[i] <= ima_q[i+LANES];
               wei_q[i] <= wei_q[i+LANES];
            end else begin
               ima_q[i] <= '0;
               wei_q[i] <= '0;
            end
         end
      end
   end

   // Sum of the LANES products handled in the current beat.
   always_comb begin
      beat_sum = '0;
      prod     = '0;
      for (int l = 0; l < LANES; l++) begin
         prod     = PROD_W'(ima_q[l]) * PROD_W'(wei_q[l]);
         beat_sum = beat_sum + ACC_W'(prod);
      end
   end

   // Post-processing: bias add, floor shift, optional ReLU, saturation.
   always_comb begin
      sum     = SAT_W'(acc) + SAT_W'(bias_q);
      shifted = sum >>> SHIFT;
      if (relu_q && shifted[SAT_W-1]) shifted = '0;
      if (shifted > OUT_MAX)      result = OUT_MAX[OUT_W-1:0];
      else if (shifted < OUT_MIN) result = OUT_MIN[OUT_W-1:0];
      else                        result = shifted[OUT_W-1:0];
   end

   // Accumulator, beat counter and registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         beat  <= '0;
         out_q <= '0;
      end else if (accept) begin
         acc  <= '0;
         beat <= '0;
      end else if (state == MAC) begin
         acc <= acc + beat_sum;
         if (!last_beat) beat <= beat + 1'b1;
      end else if (state == POST) begin
         out_q <= result;
      end
   end
endmodule

// File: doc/conv_core_seq.md
Name: conv_core_seq

Overview:
Parametrised successor to the single-shot 7x7 convolution core. Accepts one KSIZE x KSIZE window of signed pixels and signed weights plus a bias. Accumulates the products over ceil(KSIZE*KSIZE/LANES) MAC beats, then applies arithmetic shift, optional ReLU and saturation. Sits between the window buffer and the output feature-map writer, with ready/valid flow control on both sides.

Parameters:
KSIZE, 7, kernel edge; TAPS = KSIZE*KSIZE
IMG_W, 8, signed pixel width
WEI_W, 16, signed weight width
BIAS_W, 32, signed bias width
OUT_W, 32, signed result width (saturated)
LANES, 7, multipliers used per beat, 1..TAPS
SHIFT, 0, arithmetic right shift applied after bias add

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  request; accepted on a rising edge where enable && ready
ready  out  1  high only in IDLE with rst low
ima  in  TAPS*IMG_W  tap i at [i*IMG_W +: IMG_W], signed
wei  in  TAPS*WEI_W  tap i at [i*WEI_W +: WEI_W], signed
bias  in  BIAS_W  signed
relu_en  in  1  sampled with the request
out_reg  out  OUT_W  signed result, registered
valid  out  1  result available; held until out_ready
out_ready  in  1  consumer accepts; transfer on valid && out_ready

Behaviour:
- Reset (async, immediate): state=IDLE, valid=0, out_reg=0, accumulator=0, beat=0. ready=0 while rst high.
- States: IDLE, MAC, POST, OUT.
- IDLE:
  - ready=1.
  - At acceptance edge T0: latch ima, wei, bias, relu_en into internal registers, clear accumulator and beat, go to MAC.
  - Inputs may change after T0 with no effect.
- MAC:
  - Beat count B = ceil(TAPS/LANES). Beat b adds taps b*LANES .. b*LANES+LANES-1. Taps with index >= TAPS contribute 0.
  - Products are full IMG_W+WEI_W signed.
  - Accumulator width ACC_W = IMG_W+WEI_W+clog2(TAPS)+1; no overflow is possible.
  - After beat B-1 (edge T0+B), go to POST.
- POST: compute in one cycle, registered at edge T0+B+1:
  - r = acc + sign-extended bias (ACC_W+1 bits, or wider if BIAS_W requires it).
  - r >>>= SHIFT (floor).
  - If relu_en and r<0, r=0.
  - Saturate to the signed OUT_W range.
  - Result goes to out_reg; valid=1; go to OUT.
  - Latency: valid visible after edge T0+B+1 (defaults: B=7, so 8 cycles).
- OUT:
  - valid=1 and out_reg stable until the edge where out_ready=1. That edge returns to IDLE and clears valid.
  - out_reg holds its value until the next result is written.
- Flow control:
  - enable while ready=0 is ignored, not queued. The requester must hold enable until it sees ready.
  - out_ready while valid=0 has no effect.
  - enable is never accepted in the same cycle as the out_ready transfer. ready first rises one cycle after the transfer.
  - Minimum issue interval is B+3 cycles with out_ready tied high.
- Reset mid-operation (MAC, POST or OUT): the packet is discarded and no valid is produced. Next packet after reset must be unaffected by the aborted one.
- LANES=TAPS gives B=1. LANES that is not a divisor of TAPS zero-pads the final beat.

Test Plan:
1. Defaults; all ima=1, wei=1, bias=0, relu_en=0, out_ready=1 -> out_reg=49, valid rises 8 cycles after acceptance for 1 cycle, ready low from T0 until one cycle after transfer.
2. Defaults; all ima=-128, wei=32767, bias=0 -> relu_en=0 gives out_reg=-205514624; relu_en=1 gives out_reg=0.
3. OUT_W=16; all ima=127, wei=32767, bias=0 -> out_reg=32767 (saturated); all ima=-128, wei=32767 -> out_reg=-32768.
4. Backpressure: out_ready=0 for 20 cycles after valid -> valid and out_reg stable, enable pulses ignored with ready=0; out_ready=1 -> valid low the next cycle, ready high, then a new packet is accepted.
5. Reset mid-MAC: assert rst during beat 3 -> valid=0 and out_reg=0 immediately, no result emitted; next packet (case 1 stimulus) returns 49.
6. LANES=49 and LANES=4 (B=13); tap i ima=i-24, wei=1, bias=-5, SHIFT=0 -> out_reg=-5, latency 2 and 14 cycles respectively; repeat with SHIFT=1 -> -3.
